// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share one UART
// transmitter. A character is accepted from the winning requester, handed to
// the transmitter with a one-cycle send_request pulse, and the arbiter then
// waits for the transmitter's tx_done before arbitrating again.
//
// Optional feature (compile-time macro UART_TX_ARB_LOCK_EN):
//   Adds input req_lock. A requester that won the previous arbitration and
//   still holds req_lock and req_valid wins again, so multi-character
//   messages are sent without interleaving. Without the macro the port does
//   not exist and arbitration is pure round-robin.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous active-high reset
//   req_valid    in   [NUM_REQ]            requester i has a character
//   req_data     in   [NUM_REQ*DATA_BITS]  requester i's character slice
//   req_lock     in   [NUM_REQ]            (UART_TX_ARB_LOCK_EN only)
//   req_ready    out  [NUM_REQ]            one-cycle accept pulse
//   send_request out  1                    start pulse to transmitter
//   tx_data      out  [DATA_BITS]          character to transmitter
//   tx_busy      in   1                    transmitter busy
//   tx_done      in   1                    transmitter finished character
//   grant_id     out  [clog2(NUM_REQ)]     current / most recent winner
//   arb_busy     out  1                    high whenever not IDLE
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
`ifdef UART_TX_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]             req_lock,
`endif
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           send_request,
   output logic [DATA_BITS-1:0]           tx_data,
   input  logic                           tx_busy,
   input  logic                           tx_done,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           arb_busy
);

   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [GW-1:0]        r_last_grant;
   logic [GW-1:0]        r_grant_id;
   logic [DATA_BITS-1:0] r_tx_data;
   logic [NUM_REQ-1:0]   r_req_ready;
   logic                 r_send;
   logic                 r_arb_busy;

   state_t               w_state_nxt;
   logic [GW-1:0]        w_last_nxt;
   logic [GW-1:0]        w_gid_nxt;
   logic [DATA_BITS-1:0] w_data_nxt;
   logic [NUM_REQ-1:0]   w_ready_nxt;
   logic                 w_send_nxt;

   logic [GW:0]          w_sum;
   logic                 w_found;
   logic [GW-1:0]        w_winner;
   logic [NUM_REQ-1:0]   w_win_onehot;
   logic [DATA_BITS-1:0] w_win_data;

   // Winner search: first valid bit at last_grant+1, +2, ... modulo NUM_REQ.
   // One extra bit in w_sum holds the unwrapped index before the modulo fold.
   always_comb begin
      w_sum        = '0;
      w_found      = 1'b0;
      w_winner     = r_last_grant;
      w_win_onehot = '0;
      w_win_data   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_last_grant} + (GW+1)'(k + 1);
         if (w_sum >= (GW+1)'(NUM_REQ)) begin
            w_sum = w_sum - (GW+1)'(NUM_REQ);
         end
         if (!w_found && req_valid[w_sum[GW-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[GW-1:0];
         end
      end
`ifdef UART_TX_ARB_LOCK_EN
      // A locked previous winner keeps the transmitter regardless of rotation.
      if (req_lock[r_last_grant] && req_valid[r_last_grant]) begin
         w_winner = r_last_grant;
      end
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         w_win_onehot[i] = (w_winner == GW'(i));
         if (w_winner == GW'(i)) begin
            w_win_data = req_data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   // Next-state and next-output logic; all outputs come from registers.
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last_grant;
      w_gid_nxt   = r_grant_id;
      w_data_nxt  = r_tx_data;
      w_ready_nxt = '0;
      w_send_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if ((|req_valid) && !tx_busy) begin
               w_state_nxt = GRANT;
               w_ready_nxt = w_win_onehot;
               w_send_nxt  = 1'b1;
               w_data_nxt  = w_win_data;
               w_gid_nxt   = w_winner;
               w_last_nxt  = w_winner;
            end
         end
         GRANT: begin
            // tx_done is not looked at here; only WAIT_DONE reacts to it.
            w_state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= GW'(NUM_REQ - 1);
         r_grant_id   <= '0;
         r_tx_data    <= '0;
         r_req_ready  <= '0;
         r_send       <= 1'b0;
         r_arb_busy   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_nxt;
         r_grant_id   <= w_gid_nxt;
         r_tx_data    <= w_data_nxt;
         r_req_ready  <= w_ready_nxt;
         r_send       <= w_send_nxt;
         r_arb_busy   <= (w_state_nxt != IDLE);
      end
   end

   assign req_ready    = r_req_ready;
   assign send_request = r_send;
   assign tx_data      = r_tx_data;
   assign grant_id     = r_grant_id;
   assign arb_busy     = r_arb_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, DATA_BITS=8). A reference
// model samples the DUT inputs on every rising edge, decides from the
// round-robin rules whether a character is granted and to whom, and queues
// the expected grant. A monitor on the falling edge pops and compares every
// send_request the DUT presents. A behavioural transmitter answers each
// send_request with tx_done after a random (or fixed 20-cycle) delay.
// Supports builds with UART_TX_ARB_LOCK_EN defined.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DB = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*DB-1:0] req_data = '0;
`ifdef UART_TX_ARB_LOCK_EN
   logic [N-1:0]    req_lock = '0;
`endif
   logic [N-1:0]    req_ready;
   logic            send_request;
   logic [DB-1:0]   tx_data;
   logic            tx_busy = 1'b0;
   logic            tx_done = 1'b0;
   logic [1:0]      grant_id;
   logic            arb_busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
`ifdef UART_TX_ARB_LOCK_EN
      .req_lock    (req_lock),
`endif
      .req_ready   (req_ready),
      .send_request(send_request),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .arb_busy    (arb_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int            cyc;
      int            id;
      logic [DB-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   int            cyc    = 0;
   bit            m_out  = 1'b0;   // a character is granted and not yet done
   int            m_ge   = 0;      // edge number of the last grant
   int            m_last = N - 1;
   logic [DB-1:0] m_data = '0;

   function automatic int pick_winner(input logic [N-1:0] v, input int last,
                                      input logic [N-1:0] lk);
      if ((((lk & v) >> last) & 1) != 0) return last;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (last + k) % N;
         if (((v >> j) & 1) != 0) return j;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge reset) begin
      int            w;
      logic [N-1:0]  lk;
      logic [DB-1:0] d;
      if (reset) begin
         m_out  <= 1'b0;
         m_last <= N - 1;
         m_data <= '0;
         exp_q.delete();
      end else begin
`ifdef UART_TX_ARB_LOCK_EN
         lk = req_lock;
`else
         lk = '0;
`endif
         cyc <= cyc + 1;
         if (m_out) begin
            // tx_done counts only from the edge after the grant cycle onward
            if ((cyc + 1 >= m_ge + 2) && tx_done) m_out <= 1'b0;
         end else if (req_valid != '0 && !tx_busy) begin
            w = pick_winner(req_valid, m_last, lk);
            d = DB'(req_data >> (w * DB));
            exp_q.push_back('{cyc + 1, w, d});
            m_out  <= 1'b1;
            m_ge   <= cyc + 1;
            m_last <= w;
            m_data <= d;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         chk("arb_busy", 32'(arb_busy), 32'(m_out));
         chk("tx_data_hold", 32'(tx_data), 32'(m_data));
         if (send_request === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_grant: got grant_id %0d expected no grant at %0t",
                        grant_id, $time);
            end else begin
               e = exp_q.pop_front();
               chk("grant_cycle", 32'(cyc), 32'(e.cyc));
               chk("grant_id", 32'(grant_id), 32'(e.id));
               chk("grant_data", 32'(tx_data), 32'(e.data));
               chk("req_ready", 32'(req_ready), 32'(1 << e.id));
            end
         end else begin
            chk("req_ready_quiet", 32'(req_ready), 32'd0);
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               tests++;
               fails++;
               $display("FAIL missed_grant: got no send_request expected grant to %0d at %0t",
                        e.id, $time);
            end
         end
      end
   end

   // ---------------- transmitter model ----------------
   bit rand_en = 1'b0;
   bit tx_long = 1'b0;
   int tx_cnt  = 0;

   always @(negedge clk or posedge reset) begin
      if (reset) begin
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
         tx_cnt  <= 0;
      end else begin
         tx_done <= 1'b0;
         if (send_request) begin
            tx_busy <= 1'b1;
            tx_cnt  <= tx_long ? 20 : int'($urandom_range(2, 20));
         end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) begin
               tx_done <= 1'b1;
               tx_busy <= 1'b0;
            end
         end else if (rand_en) begin
            // idle transmitter occasionally busy, or pulsing a stray tx_done
            tx_busy <= ($urandom_range(0, 7) == 0);
            tx_done <= ($urandom_range(0, 31) == 0);
         end else begin
            tx_busy <= 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_grant(input string nm);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (send_request !== 1'b1 && k < 80);
      chk(nm, 32'(send_request), 32'd1);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((arb_busy || tx_busy || tx_cnt != 0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached", 32'(arb_busy), 32'd0);
   endtask

   task automatic run_random(input int n);
      rand_en = 1'b1;
      repeat (n) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               // accepted: sometimes queue the next character straight away
               req_valid[i] = ($urandom_range(0, 1) == 0);
               req_data[i*DB +: DB] = DB'($urandom);
            end else if (req_valid[i]) begin
               if ($urandom_range(0, 63) == 0) req_valid[i] = 1'b0;   // withdrawal
            end else if ($urandom_range(0, 7) == 0) begin
               req_valid[i] = 1'b1;
               req_data[i*DB +: DB] = DB'($urandom);
            end
         end
`ifdef UART_TX_ARB_LOCK_EN
         if ($urandom_range(0, 15) == 0) req_lock = N'($urandom);
`endif
      end
      rand_en = 1'b0;
   endtask

   initial begin
      int order [5] = '{0, 1, 2, 3, 0};

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_send", 32'(send_request), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_arb_busy", 32'(arb_busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // single requester, one-cycle latency
      req_valid = 4'b0001;
      req_data  = 32'h0000_0055;
      @(negedge clk);
      chk("first_ready", 32'(req_ready), 32'h1);
      chk("first_send", 32'(send_request), 32'd1);
      chk("first_data", 32'(tx_data), 32'h55);
      chk("first_id", 32'(grant_id), 32'd0);
      req_valid = '0;
      wait_idle();

      // all requesters held valid after a fresh reset: 0,1,2,3,0
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tx_long = 1'b1;
      req_data  = 32'hD3C2_B1A0;
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_grant("rr_grant_seen");
         chk("rr_order", 32'(grant_id), 32'(order[g]));
      end
      req_valid = '0;
      wait_idle();
      tx_long = 1'b0;

      run_random(3000);
      req_valid = '0;
      wait_idle();

      // reset in the middle of WAIT_DONE
      tx_long = 1'b1;
      req_valid = 4'b0100;
      req_data  = 32'h0033_0000;
      wait_grant("pre_reset_grant");
      req_valid = '0;
      repeat (5) @(negedge clk);
      chk("wait_done_busy", 32'(arb_busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_send", 32'(send_request), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd0);
      chk("abort_tx_data", 32'(tx_data), 32'd0);
      chk("abort_grant_id", 32'(grant_id), 32'd0);
      chk("abort_arb_busy", 32'(arb_busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      req_valid = 4'b0010;
      req_data  = 32'h0000_A700;
      wait_grant("post_reset_grant");
      chk("post_reset_id", 32'(grant_id), 32'd1);
      chk("post_reset_data", 32'(tx_data), 32'hA7);
      req_valid = '0;
      wait_idle();
      tx_long = 1'b0;

      run_random(1500);
      req_valid = '0;
      wait_idle();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish by 2000000");
      $fatal(1, "timeout");
   end

endmodule
